mesh_run_ctrl: RTL
==================

Name: mesh_run_ctrl

Overview:
Run sequencer for the 2x4 mesh traffic test. Holds the per-PE traffic configuration written by a host, and drives the mesh's PE config, enable and flush wires. On a start pulse it flushes, arms and enables the selected PEs, then waits until every selected PE reports send and receive completion, or until timeout/abort. Reports cycle count and a completion bitmap.

Parameters:
CNT_W, 16, width of run-cycle counter and status_cycles
TIMEOUT, 16'hFFFF, max RUN cycles before forced stop; legal range 1..2^CNT_W-1
FLUSH_CYCLES, 4, cycles pe_flush_wire is held; minimum 1

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
cfg_wr  in  1  config write strobe
cfg_pe  in  3  target PE index 0..7
cfg_field  in  3  0 dbg_mode, 1 send_num, 2 recv_num, 3 rate, 4 dst_seq, 5 mode, 6 run-mask bit
cfg_wdata  in  24  write data, LSB-aligned to field width
cfg_err  out  1  1-cycle pulse: write rejected (busy or field 7)
start  in  1  start pulse
abort  in  1  abort request
busy  out  1  high in every state except IDLE
done  out  1  1-cycle pulse on entry to DONE
status_timeout  out  1  last run ended by timeout
status_abort  out  1  last run ended by abort
status_cycles  out  CNT_W  RUN cycles of last run
status_fin_map  out  8  per-PE (send&recv finish) at end of last run
pe_enable  out  8  to mesh
pe_dbg_mode_wire  out  8  to mesh, bit i = PE i
pe_send_num_wire  out  24  3 bits per PE, PE i at [3i+2:3i]
pe_receive_num_wire  out  24  3 bits per PE
pe_rate_wire  out  32  4 bits per PE
pe_dst_seq_wire  out  192  24 bits per PE
pe_mode_wire  out  32  4 bits per PE
pe_flush_wire  out  8  to mesh
pe_task_send_finish_flag  in  8  from mesh
pe_task_receive_finish_flag  in  8  from mesh

Behaviour:
- Reset (rst_n low at clk edge): all config registers, run mask, status, counters, and all outputs = 0; state IDLE.
- Config: cfg_wr in IDLE writes field of cfg_pe next cycle; field 6 writes mask[cfg_pe]=cfg_wdata[0]. Config outputs reflect registers directly, constant during a run. cfg_wr when busy, or field 7: no write, cfg_err=1 next cycle.
- FSM IDLE->FLUSH->ARM->RUN->DONE->IDLE.
- IDLE: start=1 at cycle T -> FLUSH at T+1; status_* cleared at T+1. Start while busy ignored.
- FLUSH: pe_flush_wire=mask for exactly FLUSH_CYCLES cycles (T+1..T+FLUSH_CYCLES); pe_enable=0.
- ARM: one cycle, flush=0, enable=0; run counter cleared.
- RUN: pe_enable=mask. Finish flags evaluated only in RUN: all_done = &(~mask | (send & recv)). Counter increments each RUN cycle; cnt+1 is the count including the current cycle.
  - all_done -> DONE, status_cycles=cnt+1.
  - else cnt+1==TIMEOUT -> DONE, status_timeout=1, status_cycles=TIMEOUT.
  - all_done has priority over timeout in the same cycle.
- Mask 0: all_done true on first RUN cycle -> status_cycles=1.
- abort=1 in FLUSH/ARM/RUN -> DONE next cycle, status_abort=1, status_cycles=current count. Abort has priority over done/timeout. Ignored in IDLE/DONE.
- DONE: one cycle. done=1, pe_enable=0, pe_flush=0, status_fin_map=send&recv&mask sampled that cycle. Next state IDLE.
- Status holds until the next start.
- Reset mid-run: immediate return to IDLE with all outputs 0.

Optional Feature:
MESH_RUN_CTRL_STAMP_EN. When defined: adds inputs stamp_sel[2:0] and output stamp_out[CNT_W-1:0], plus eight CNT_W stamp registers. Each stamp captures cnt+1 on the first RUN cycle that PE's send&recv is high; stamps clear in ARM. stamp_out is the combinational stamp of stamp_sel, 0 if never reached. When undefined: ports and registers absent; all other behaviour identical.

Test Plan:
- Write PE5 dst_seq=24'hABCDEF and PE2 rate=4'h9 in IDLE -> pe_dst_seq_wire[143:120]=ABCDEF, pe_rate_wire[11:8]=9; cfg_err stays 0.
- Mask=0x03, start at T -> flush=0x03 for T+1..T+4, ARM T+5, enable=0x03 from T+6. Both PEs' flags high at T+15 -> done at T+16, status_cycles=10, fin_map=0x03.
- TIMEOUT=20, mask=0x81, only PE0 finishes -> done after 20 RUN cycles, status_timeout=1, status_cycles=20, fin_map=0x01.
- abort in 3rd RUN cycle -> DONE next cycle, status_abort=1, status_cycles=2, pe_enable=0; all_done asserted in the same cycle as abort -> status_abort still 1.
- cfg_wr during RUN -> cfg_err pulse, config outputs unchanged; start during RUN ignored.
- rst_n low for one cycle mid-RUN -> next cycle all outputs 0, busy=0, state IDLE.

Source files
------------

// File: rtl/mesh_run_ctrl.sv
// Run sequencer for the 2x4 mesh traffic test: per-PE config storage plus FLUSH/ARM/RUN/DONE sequencing.
// Optional per-PE finish-cycle stamps are enabled by defining MESH_RUN_CTRL_STAMP_EN.

module mesh_run_pe_cfg
`ifdef MESH_RUN_CTRL_STAMP_EN
#(
   parameter int CNT_W = 16
)
`endif
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr,
   input  logic [2:0]       field,
   input  logic [23:0]      wdata,
`ifdef MESH_RUN_CTRL_STAMP_EN
   input  logic             stamp_clr,
   input  logic             stamp_run,
   input  logic             fin,
   input  logic [CNT_W-1:0] cnt_nxt,
   output logic [CNT_W-1:0] stamp,
`endif
   output logic             dbg_mode,
   output logic [2:0]       send_num,
   output logic [2:0]       recv_num,
   output logic [3:0]       rate,
   output logic [23:0]      dst_seq,
   output logic [3:0]       mode,
   output logic             run_mask
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dbg_mode <= 1'b0;
         send_num <= '0;
         recv_num <= '0;
         rate     <= '0;
         dst_seq  <= '0;
         mode     <= '0;
         run_mask <= 1'b0;
      end else if (wr) begin
         case (field)
            3'd0: dbg_mode <= wdata[0];
            3'd1: send_num <= wdata[2:0];
            3'd2: recv_num <= wdata[2:0];
            3'd3: rate     <= wdata[3:0];
            3'd4: dst_seq  <= wdata;
            3'd5: mode     <= wdata[3:0];
            3'd6: run_mask <= wdata[0];
            default: ;
         endcase
      end
   end

`ifdef MESH_RUN_CTRL_STAMP_EN
   // A stamp of zero means "not reached": cnt_nxt is never below 1 in RUN.
   always_ff @(posedge clk) begin
      if (!rst_n || stamp_clr)
         stamp <= '0;
      else if (stamp_run && fin && stamp == '0)
         stamp <= cnt_nxt;
   end
`endif

endmodule

module mesh_run_ctrl #(
   parameter int            CNT_W        = 16,
   parameter logic [CNT_W-1:0] TIMEOUT   = 16'hFFFF,
   parameter int            FLUSH_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_wr,
   input  logic [2:0]       cfg_pe,
   input  logic [2:0]       cfg_field,
   input  logic [23:0]      cfg_wdata,
   output logic             cfg_err,
   input  logic             start,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic             status_timeout,
   output logic             status_abort,
   output logic [CNT_W-1:0] status_cycles,
   output logic [7:0]       status_fin_map,
   output logic [7:0]       pe_enable,
   output logic [7:0]       pe_dbg_mode_wire,
   output logic [23:0]      pe_send_num_wire,
   output logic [23:0]      pe_receive_num_wire,
   output logic [31:0]      pe_rate_wire,
   output logic [191:0]     pe_dst_seq_wire,
   output logic [31:0]      pe_mode_wire,
   output logic [7:0]       pe_flush_wire,
`ifdef MESH_RUN_CTRL_STAMP_EN
   input  logic [2:0]       stamp_sel,
   output logic [CNT_W-1:0] stamp_out,
`endif
   input  logic [7:0]       pe_task_send_finish_flag,
   input  logic [7:0]       pe_task_receive_finish_flag
);

   localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FLUSH,
      S_ARM,
      S_RUN,
      S_DONE
   } state_t;

   state_t            state;
   logic [FC_W-1:0]   fcnt;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_nxt;
   logic [7:0]        mask;
   logic [7:0]        fin;
   logic              all_done;
   logic              cfg_ok;
   logic [7:0]        pe_wr;

   logic [7:0][2:0]   send_num;
   logic [7:0][2:0]   recv_num;
   logic [7:0][3:0]   rate;
   logic [7:0][23:0]  dst_seq;
   logic [7:0][3:0]   mode;
`ifdef MESH_RUN_CTRL_STAMP_EN
   logic [7:0][CNT_W-1:0] stamp;
`endif

   assign busy     = (state != S_IDLE);
   assign cnt_nxt  = cnt + 1'b1;
   assign fin      = pe_task_send_finish_flag & pe_task_receive_finish_flag;
   assign all_done = &(~mask | fin);
   assign cfg_ok   = cfg_wr && !busy && (cfg_field != 3'd7);

   assign pe_send_num_wire    = send_num;
   assign pe_receive_num_wire = recv_num;
   assign pe_rate_wire        = rate;
   assign pe_dst_seq_wire     = dst_seq;
   assign pe_mode_wire        = mode;
`ifdef MESH_RUN_CTRL_STAMP_EN
   assign stamp_out = stamp[stamp_sel];
`endif

   for (genvar i = 0; i < 8; i++) begin : g_pe
      assign pe_wr[i] = cfg_ok && (cfg_pe == 3'(i));

      mesh_run_pe_cfg
`ifdef MESH_RUN_CTRL_STAMP_EN
      #(.CNT_W(CNT_W))
`endif
      u_cfg (
         .clk      (clk),
         .rst_n    (rst_n),
         .wr       (pe_wr[i]),
         .field    (cfg_field),
         .wdata    (cfg_wdata),
`ifdef MESH_RUN_CTRL_STAMP_EN
         .stamp_clr(state == S_ARM),
         .stamp_run(state == S_RUN),
         .fin      (fin[i]),
         .cnt_nxt  (cnt_nxt),
         .stamp    (stamp[i]),
`endif
         .dbg_mode (pe_dbg_mode_wire[i]),
         .send_num (send_num[i]),
         .recv_num (recv_num[i]),
         .rate     (rate[i]),
         .dst_seq  (dst_seq[i]),
         .mode     (mode[i]),
         .run_mask (mask[i])
      );
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         fcnt           <= '0;
         cnt            <= '0;
         cfg_err        <= 1'b0;
         done           <= 1'b0;
         status_timeout <= 1'b0;
         status_abort   <= 1'b0;
         status_cycles  <= '0;
         status_fin_map <= '0;
         pe_enable      <= '0;
         pe_flush_wire  <= '0;
      end else begin
         cfg_err <= cfg_wr && (busy || cfg_field == 3'd7);
         done    <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state          <= S_FLUSH;
                  fcnt           <= '0;
                  cnt            <= '0;
                  pe_flush_wire  <= mask;
                  status_timeout <= 1'b0;
                  status_abort   <= 1'b0;
                  status_cycles  <= '0;
                  status_fin_map <= '0;
               end
            end
            S_FLUSH: begin
               if (abort) begin
                  state         <= S_DONE;
                  done          <= 1'b1;
                  status_abort  <= 1'b1;
                  status_cycles <= cnt;
                  pe_flush_wire <= '0;
               end else if (fcnt == FC_W'(FLUSH_CYCLES - 1)) begin
                  state         <= S_ARM;
                  pe_flush_wire <= '0;
               end else begin
                  fcnt <= fcnt + 1'b1;
               end
            end
            S_ARM: begin
               if (abort) begin
                  state         <= S_DONE;
                  done          <= 1'b1;
                  status_abort  <= 1'b1;
                  status_cycles <= cnt;
               end else begin
                  state     <= S_RUN;
                  cnt       <= '0;
                  pe_enable <= mask;
               end
            end
            S_RUN: begin
               // Abort beats completion, completion beats timeout.
               if (abort) begin
                  state         <= S_DONE;
                  done          <= 1'b1;
                  pe_enable     <= '0;
                  status_abort  <= 1'b1;
                  status_cycles <= cnt;
               end else if (all_done) begin
                  state         <= S_DONE;
                  done          <= 1'b1;
                  pe_enable     <= '0;
                  status_cycles <= cnt_nxt;
               end else if (cnt_nxt == TIMEOUT) begin
                  state          <= S_DONE;
                  done           <= 1'b1;
                  pe_enable      <= '0;
                  status_timeout <= 1'b1;
                  status_cycles  <= TIMEOUT;
               end else begin
                  cnt <= cnt_nxt;
               end
            end
            S_DONE: begin
               state          <= S_IDLE;
               status_fin_map <= fin & mask;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
